// File: rtl/ucode_loader_if.sv
// Byte-in / word-out bus between the UART receiver, the boot loader and uCode program memory.
interface ucode_loader_if #(
  parameter int ADDR_SZ = 8
);
  logic [7:0]         i_rx_data;
  logic               i_rx_valid;
  logic               o_wr;
  logic [ADDR_SZ-1:0] o_waddr;
  logic [15:0]        o_wdata;
  logic               o_run;
  logic               o_busy;
  logic               o_error;

  modport slave (
    input  i_rx_data, i_rx_valid,
    output o_wr, o_waddr, o_wdata, o_run, o_busy, o_error
  );

  modport master (
    output i_rx_data, i_rx_valid,
    input  o_wr, o_waddr, o_wdata, o_run, o_busy, o_error
  );
endinterface

// File: rtl/ucode_loader.sv
// Framed byte-stream boot loader: SYNC, ADDR, COUNT, data words, optional CSUM, then releases the CPU.
// Define LOADER_CHECKSUM_EN to require the trailing checksum byte.
module ucode_loader #(
  parameter int ADDR_SZ = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  ucode_loader_if.slave bus
);
  localparam logic [7:0] SYNC = 8'h55;
  localparam int         TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_COUNT, S_DATA_HI, S_DATA_LO, S_CSUM
  } state_t;

  function automatic logic [8:0] words_of(input logic [7:0] c);
    return (c == 8'd0) ? 9'd256 : {1'b0, c};
  endfunction

  state_t             state_q;
  logic               wr_q, run_q, busy_q, err_q;
  logic [ADDR_SZ-1:0] waddr_q, ptr_q;
  logic [15:0]        wdata_q;
  logic [7:0]         hi_q, sum_q;
  logic [8:0]         remain_q;
  logic [TW-1:0]      tmo_q;

  logic [7:0]         sum_d;
  logic               expire_d;

  always_comb begin
    sum_d    = sum_q + bus.i_rx_data;
    expire_d = (state_q != S_IDLE) && !bus.i_rx_valid && (tmo_q == TW'(TIMEOUT - 1));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      run_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
      hi_q     <= '0;
      sum_q    <= '0;
      remain_q <= '0;
      tmo_q    <= '0;
    end else begin
      wr_q <= 1'b0;
      // Idle-gap counter only runs inside a frame; any accepted byte restarts it.
      if (state_q == S_IDLE || bus.i_rx_valid) tmo_q <= '0;
      else                                     tmo_q <= tmo_q + TW'(1);

      if (expire_d) begin
        err_q   <= 1'b1;
        busy_q  <= 1'b0;
        state_q <= S_IDLE;
      end else if (bus.i_rx_valid) begin
        case (state_q)
          S_IDLE: begin
            if (bus.i_rx_data == SYNC) begin
              run_q   <= 1'b0;
              err_q   <= 1'b0;
              busy_q  <= 1'b1;
              sum_q   <= '0;
              state_q <= S_ADDR;
            end
          end
          S_ADDR: begin
            ptr_q   <= ADDR_SZ'(bus.i_rx_data);
            sum_q   <= sum_d;
            state_q <= S_COUNT;
          end
          S_COUNT: begin
            remain_q <= words_of(bus.i_rx_data);
            sum_q    <= sum_d;
            state_q  <= S_DATA_HI;
          end
          S_DATA_HI: begin
            hi_q    <= bus.i_rx_data;
            sum_q   <= sum_d;
            state_q <= S_DATA_LO;
          end
          S_DATA_LO: begin
            wr_q     <= 1'b1;
            waddr_q  <= ptr_q;
            wdata_q  <= {hi_q, bus.i_rx_data};
            ptr_q    <= ptr_q + ADDR_SZ'(1);
            remain_q <= remain_q - 9'd1;
            sum_q    <= sum_d;
            if (remain_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_q <= S_CSUM;
`else
              run_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
`endif
            end else begin
              state_q <= S_DATA_HI;
            end
          end
          S_CSUM: begin
            // Memory is already written; a bad sum only keeps the CPU held.
            if (sum_d == 8'd0) run_q <= 1'b1;
            else               err_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_wr    = wr_q;
  assign bus.o_waddr = waddr_q;
  assign bus.o_wdata = wdata_q;
  assign bus.o_run   = run_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_error = err_q;
endmodule
